// File: rtl/ctrl_reg_bank.sv
// Multi-channel control/status register bank on a word-addressed bus: R/W channel controls,
// sticky W1C event status with interrupt enable, self-clearing pulses and a read-only ID.
module ctrl_reg_bank #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_CHAN   = 4,
   parameter int unsigned CHAN_WIDTH = 16,
   parameter int unsigned BASE_ADDR  = 0,
   parameter logic [31:0] VERSION    = 32'h0002_0001
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [ADDR_WIDTH-1:0]          address,
   input  logic                           write_enable,
   input  logic [DATA_WIDTH-1:0]          write_data,
   input  logic [DATA_WIDTH/8-1:0]        write_strobe,
   input  logic                           read_enable,
   output logic [DATA_WIDTH-1:0]          read_data,
   output logic                           read_valid,
   output logic                           access_error,
   output logic [NUM_CHAN*CHAN_WIDTH-1:0] chan_ctrl,
   input  logic [NUM_CHAN-1:0]            event_in,
   output logic [NUM_CHAN-1:0]            pulse_out,
   output logic                           irq
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned OffW     = ADDR_WIDTH + 1;

   localparam logic [OffW-1:0]       BaseExt   = OffW'(BASE_ADDR);
   localparam logic [OffW-1:0]       OffStatus = OffW'(NUM_CHAN);
   localparam logic [OffW-1:0]       OffIntEn  = OffW'(NUM_CHAN + 1);
   localparam logic [OffW-1:0]       OffPulse  = OffW'(NUM_CHAN + 2);
   localparam logic [OffW-1:0]       OffId     = OffW'(NUM_CHAN + 3);
   localparam logic [OffW-1:0]       OffEnd    = OffW'(NUM_CHAN + 4);
   localparam logic [DATA_WIDTH-1:0] IdValue   = DATA_WIDTH'(VERSION);

   logic [CHAN_WIDTH-1:0] ctrl_q [NUM_CHAN];
   logic [CHAN_WIDTH-1:0] ctrl_d [NUM_CHAN];
   logic [NUM_CHAN-1:0]   status_q, status_d;
   logic [NUM_CHAN-1:0]   int_en_q, int_en_d;
   logic [NUM_CHAN-1:0]   pulse_q, pulse_d;
   logic [DATA_WIDTH-1:0] read_data_q;
   logic                  read_valid_q;
   logic                  access_error_q, access_error_d;

   logic [OffW-1:0]       off;
   logic                  mapped;
   logic                  sel_status, sel_int_en, sel_pulse, sel_id;
   logic [DATA_WIDTH-1:0] wmask, wbits, rdata_mux;
   logic                  unused_bits;

   // Extra top bit catches addresses below BASE_ADDR as a borrow.
   assign off        = {1'b0, address} - BaseExt;
   assign mapped     = ~off[OffW-1] && (off < OffEnd);
   assign sel_status = (off == OffStatus);
   assign sel_int_en = (off == OffIntEn);
   assign sel_pulse  = (off == OffPulse);
   assign sel_id     = (off == OffId);

   always_comb begin
      wmask = '0;
      for (int k = 0; k < NumBytes; k++) begin
         wmask[k*8 +: 8] = {8{write_strobe[k]}};
      end
   end

   assign wbits       = write_data & wmask;
   assign unused_bits = ^{wbits, wmask};

   always_comb begin
      for (int i = 0; i < NUM_CHAN; i++) begin
         ctrl_d[i] = ctrl_q[i];
         if (write_enable && off == OffW'(i)) begin
            ctrl_d[i] = (ctrl_q[i] & ~wmask[CHAN_WIDTH-1:0]) | wbits[CHAN_WIDTH-1:0];
         end
      end

      int_en_d = int_en_q;
      if (write_enable && sel_int_en) begin
         int_en_d = (int_en_q & ~wmask[NUM_CHAN-1:0]) | wbits[NUM_CHAN-1:0];
      end

      // A new event on the same edge as its clear keeps the bit set.
      status_d = status_q;
      if (write_enable && sel_status) begin
         status_d = status_q & ~wbits[NUM_CHAN-1:0];
      end
      status_d = status_d | event_in;

      pulse_d = '0;
      if (write_enable && sel_pulse) begin
         pulse_d = wbits[NUM_CHAN-1:0];
      end

      access_error_d = (write_enable && (!mapped || sel_id)) || (read_enable && !mapped);
   end

   always_comb begin
      rdata_mux = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (off == OffW'(i)) begin
            rdata_mux = DATA_WIDTH'(ctrl_q[i]);
         end
      end
      if (sel_status) rdata_mux = DATA_WIDTH'(status_q);
      if (sel_int_en) rdata_mux = DATA_WIDTH'(int_en_q);
      if (sel_id)     rdata_mux = IdValue;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            ctrl_q[i] <= '0;
         end
         status_q       <= '0;
         int_en_q       <= '0;
         pulse_q        <= '0;
         read_data_q    <= '0;
         read_valid_q   <= 1'b0;
         access_error_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            ctrl_q[i] <= ctrl_d[i];
         end
         status_q       <= status_d;
         int_en_q       <= int_en_d;
         pulse_q        <= pulse_d;
         read_valid_q   <= read_enable;
         access_error_q <= access_error_d;
         // Mux reads pre-write state, so a same-cycle write is not visible.
         if (read_enable) begin
            read_data_q <= rdata_mux;
         end
      end
   end

   for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
      assign chan_ctrl[i*CHAN_WIDTH +: CHAN_WIDTH] = ctrl_q[i];
   end

   assign read_data    = read_data_q;
   assign read_valid   = read_valid_q;
   assign access_error = access_error_q;
   assign pulse_out    = pulse_q;
   assign irq          = |(status_q & int_en_q);

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// Table-driven bench for ctrl_reg_bank with default parameters, plus hand sequences for
// read-data hold and reset asserted during a read.
module tb_ctrl_reg_bank;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  address = '0;
   logic        write_enable = 1'b0;
   logic [31:0] write_data = '0;
   logic [3:0]  write_strobe = '0;
   logic        read_enable = 1'b0;
   logic [31:0] read_data;
   logic        read_valid;
   logic        access_error;
   logic [63:0] chan_ctrl;
   logic [3:0]  event_in = '0;
   logic [3:0]  pulse_out;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [31:0] Ver = 32'h0002_0001;

   ctrl_reg_bank dut (
      .clock       (clock),
      .reset       (reset),
      .address     (address),
      .write_enable(write_enable),
      .write_data  (write_data),
      .write_strobe(write_strobe),
      .read_enable (read_enable),
      .read_data   (read_data),
      .read_valid  (read_valid),
      .access_error(access_error),
      .chan_ctrl   (chan_ctrl),
      .event_in    (event_in),
      .pulse_out   (pulse_out),
      .irq         (irq)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic        re;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [3:0]  ev;
      logic        exp_rv;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [63:0] exp_ctrl;
      logic        exp_irq;
      logic [3:0]  exp_pulse;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic we, input logic re, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb, input logic [3:0] ev,
                      input logic exp_rv, input logic [31:0] exp_rdata, input logic exp_err,
                      input logic [63:0] exp_ctrl, input logic exp_irq,
                      input logic [3:0] exp_pulse);
      vec_t v;
      v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.strb = strb; v.ev = ev;
      v.exp_rv = exp_rv; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      v.exp_ctrl = exp_ctrl; v.exp_irq = exp_irq; v.exp_pulse = exp_pulse;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      write_enable = 1'b0;
      read_enable  = 1'b0;
      write_data   = '0;
      write_strobe = '0;
      event_in     = '0;
      address      = '0;
   endtask

   localparam logic [63:0] C1 = 64'h0000_0000_00EF_0000;
   localparam logic [63:0] C2 = 64'hFF00_0000_00EF_0000;
   localparam logic [63:0] C3 = 64'hFF00_1234_00EF_0000;
   localparam logic [63:0] C4 = 64'hFF00_5678_00EF_0000;

   initial begin
      // we re addr wdata strb ev | rv rdata err ctrl irq pulse
      for (int i = 0; i < 8; i++) begin
         add(0, 1, 8'(i), 0, 0, 0, 1, (i == 7) ? Ver : 32'h0, 0, 64'h0, 0, 4'h0);
      end
      add(1, 0, 8'h01, 32'hDEAD_BEEF, 4'b0001, 0, 0, 0, 0, C1, 0, 4'h0);
      add(0, 1, 8'h01, 0, 0, 0, 1, 32'h0000_00EF, 0, C1, 0, 4'h0);
      add(1, 0, 8'h03, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0, 0, C2, 0, 4'h0);
      add(0, 1, 8'h03, 0, 0, 0, 1, 32'h0000_FF00, 0, C2, 0, 4'h0);
      add(1, 0, 8'h05, 32'h4, 4'hF, 0, 0, 0, 0, C2, 0, 4'h0);
      add(0, 0, 8'h00, 0, 0, 4'b0101, 0, 0, 0, C2, 1, 4'h0);
      add(0, 1, 8'h04, 0, 0, 0, 1, 32'h5, 0, C2, 1, 4'h0);
      add(1, 0, 8'h04, 32'h4, 4'hF, 0, 0, 0, 0, C2, 0, 4'h0);
      add(0, 1, 8'h04, 0, 0, 0, 1, 32'h1, 0, C2, 0, 4'h0);
      add(1, 0, 8'h05, 32'h1, 4'hF, 0, 0, 0, 0, C2, 1, 4'h0);
      add(1, 0, 8'h04, 32'h1, 4'hF, 4'b0001, 0, 0, 0, C2, 1, 4'h0);
      add(0, 1, 8'h04, 0, 0, 0, 1, 32'h1, 0, C2, 1, 4'h0);
      add(1, 0, 8'h04, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, C2, 1, 4'h0);
      add(1, 0, 8'h04, 32'h1, 4'hF, 0, 0, 0, 0, C2, 0, 4'h0);
      add(0, 1, 8'h04, 0, 0, 0, 1, 32'h0, 0, C2, 0, 4'h0);
      add(1, 0, 8'h06, 32'hA, 4'hF, 0, 0, 0, 0, C2, 0, 4'hA);
      add(1, 0, 8'h06, 32'hA, 4'hF, 0, 0, 0, 0, C2, 0, 4'hA);
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, C2, 0, 4'h0);
      add(1, 0, 8'h06, 32'hF, 4'h0, 0, 0, 0, 0, C2, 0, 4'h0);
      add(0, 1, 8'h06, 0, 0, 0, 1, 32'h0, 0, C2, 0, 4'h0);
      add(0, 1, 8'h20, 0, 0, 0, 1, 32'h0, 1, C2, 0, 4'h0);
      add(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, C2, 0, 4'h0);
      add(1, 0, 8'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1, C2, 0, 4'h0);
      add(1, 0, 8'h07, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 1, C2, 0, 4'h0);
      add(0, 1, 8'h07, 0, 0, 0, 1, Ver, 0, C2, 0, 4'h0);
      add(1, 0, 8'h02, 32'h1234, 4'hF, 0, 0, 0, 0, C3, 0, 4'h0);
      add(1, 1, 8'h02, 32'hABCD_5678, 4'hF, 0, 1, 32'h1234, 0, C4, 0, 4'h0);
      add(0, 1, 8'h02, 0, 0, 0, 1, 32'h5678, 0, C4, 0, 4'h0);
      add(0, 1, 8'h08, 0, 0, 0, 1, 32'h0, 1, C4, 0, 4'h0);

      // Reset state
      #12;
      check("rst read_valid", 64'(read_valid), 64'h0);
      check("rst read_data", 64'(read_data), 64'h0);
      check("rst access_error", 64'(access_error), 64'h0);
      check("rst chan_ctrl", chan_ctrl, 64'h0);
      check("rst pulse_out", 64'(pulse_out), 64'h0);
      check("rst irq", 64'(irq), 64'h0);
      reset = 1'b1;
      step();

      foreach (vecs[n]) begin
         write_enable = vecs[n].we;
         read_enable  = vecs[n].re;
         address      = vecs[n].addr;
         write_data   = vecs[n].wdata;
         write_strobe = vecs[n].strb;
         event_in     = vecs[n].ev;
         step();
         check($sformatf("v%0d read_valid", n), 64'(read_valid), 64'(vecs[n].exp_rv));
         if (vecs[n].exp_rv) begin
            check($sformatf("v%0d read_data", n), 64'(read_data), 64'(vecs[n].exp_rdata));
         end
         check($sformatf("v%0d access_error", n), 64'(access_error), 64'(vecs[n].exp_err));
         check($sformatf("v%0d chan_ctrl", n), chan_ctrl, vecs[n].exp_ctrl);
         check($sformatf("v%0d irq", n), 64'(irq), 64'(vecs[n].exp_irq));
         check($sformatf("v%0d pulse_out", n), 64'(pulse_out), 64'(vecs[n].exp_pulse));
      end

      // read_data holds while read_valid is low
      idle_inputs();
      read_enable = 1'b1;
      address     = 8'h07;
      step();
      check("hold first read", 64'(read_data), 64'(Ver));
      idle_inputs();
      step();
      check("hold read_valid low", 64'(read_valid), 64'h0);
      check("hold read_data", 64'(read_data), 64'(Ver));

      // Reset asserted mid-read
      read_enable = 1'b1;
      address     = 8'h07;
      step();
      check("pre-reset read_valid", 64'(read_valid), 64'h1);
      #2;
      reset = 1'b0;
      #1;
      check("async rst read_valid", 64'(read_valid), 64'h0);
      check("async rst read_data", 64'(read_data), 64'h0);
      check("async rst chan_ctrl", chan_ctrl, 64'h0);
      step();
      idle_inputs();
      reset = 1'b1;
      step();
      check("post-reset read_valid", 64'(read_valid), 64'h0);
      check("post-reset read_data", 64'(read_data), 64'h0);
      read_enable = 1'b1;
      address     = 8'h01;
      step();
      check("post-reset ctrl1 read", 64'(read_data), 64'h0);
      idle_inputs();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
